apb_req_master: RTL and testbench

- APB initiator that turns a simple valid/ready request stream into single APB3/APB4 transfers and returns each completion on a valid/ready response stream.
- Used as the bus master in front of APB slaves such as the read-only register files, for example from a debug or config sequencer.
- One outstanding transfer at a time.
- A programmable watchdog aborts transfers whose slave never asserts pready.

---
 rtl/apb_req_master_if.sv | 48 ++++
 rtl/apb_req_master.sv | 116 +++++++++++
 tb/tb_apb_req_master.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// Bundle of the request stream, response stream and APB bus seen by apb_req_master.
// The master modport is the initiator's view; the slave modport is the opposite side.
interface apb_req_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

  // request stream
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_write_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;

  // response stream
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  // APB bus
  logic [ADDR_WIDTH-1:0] paddr_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
    input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output paddr_o, pwrite_o, pwdata_o, pstrb_o, psel_o, penable_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
    output rsp_ready_i, pready_i, prdata_i, pslverr_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  paddr_o, pwrite_o, pwdata_o, pstrb_o, psel_o, penable_o
  );
endinterface

// File: rtl/apb_req_master.sv
// APB initiator: converts one valid/ready request into a single APB transfer
// (SETUP then ACCESS) and returns its completion on a valid/ready response.
// A watchdog aborts ACCESS phases that never see pready. Note rst_n is an
// active-high asynchronous reset in this codebase despite its name.
module apb_req_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  apb_req_master_if.master         bus
);
  localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;
  localparam int CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  req_ready;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_WIDTH-1:0] pstrb;
  logic                  psel;
  logic                  penable;

  // Transfer sequencer: every output is a flop so nothing on the request or
  // response side reaches the APB pins combinationally.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            paddr     <= bus.req_addr_i;
            pwrite    <= bus.req_write_i;
            pwdata    <= bus.req_wdata_i;
            // reads never drive strobes on the bus
            pstrb     <= bus.req_write_i ? bus.req_strb_i : '0;
            psel      <= 1'b1;
            req_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a watchdog expiring in the same cycle
          if (bus.pready_i) begin
            rsp_rdata   <= pwrite ? '0 : bus.prdata_i;
            rsp_err     <= bus.pslverr_i;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
            // abort: psel drops without the slave ever answering
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready_o   = req_ready;
  assign bus.rsp_valid_o   = rsp_valid;
  assign bus.rsp_rdata_o   = rsp_rdata;
  assign bus.rsp_err_o     = rsp_err;
  assign bus.rsp_timeout_o = rsp_timeout;
  assign bus.paddr_o       = paddr;
  assign bus.pwrite_o      = pwrite;
  assign bus.pwdata_o      = pwdata;
  assign bus.pstrb_o       = pstrb;
  assign bus.psel_o        = psel;
  assign bus.penable_o     = penable;

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: directed scenarios plus randomized transfers, each
// checked against expectations derived from the transfer rules (access length,
// watchdog outcome, response contents) rather than from the FSM itself.
module tb_apb_req_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  apb_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_req_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // APB address/control must equal the latched request throughout a transfer
  task automatic chk_bus(input string tag, input logic [31:0] a, input logic w,
                         input logic [31:0] wd, input logic [3:0] sb);
    chk({tag, "_paddr"},  64'(bus.paddr_o),  64'(a));
    chk({tag, "_pwrite"}, 64'(bus.pwrite_o), 64'(w));
    chk({tag, "_pwdata"}, 64'(bus.pwdata_o), 64'(wd));
    chk({tag, "_pstrb"},  64'(bus.pstrb_o),  64'(sb));
  endtask

  // One complete transfer. wait_n = number of not-ready ACCESS cycles before
  // pready; stall = cycles rsp_ready is withheld (with req_valid held high).
  // Entry and exit: 1 time unit after a rising edge, DUT in IDLE.
  task automatic do_xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] sb, input int wait_n, input logic se,
                         input logic [31:0] rd, input int stall);
    logic        to_exp;
    int          n_acc;
    logic [3:0]  sb_exp;
    logic [31:0] rd_exp;
    logic        err_exp;
    to_exp  = (TO != 0) && (wait_n >= TO);
    n_acc   = to_exp ? TO : wait_n + 1;
    sb_exp  = w ? sb : 4'h0;
    rd_exp  = (to_exp || w) ? 32'h0 : rd;
    err_exp = to_exp ? 1'b1 : se;

    chk("idle_req_ready", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_write_i = w;
    bus.req_wdata_i = wd;
    bus.req_strb_i  = sb;
    @(posedge clk); #1;
    // SETUP: scramble request inputs and APB returns to prove they are ignored
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_write_i = 1'($urandom);
    bus.req_wdata_i = $urandom;
    bus.req_strb_i  = 4'($urandom);
    chk("setup_psel",      64'(bus.psel_o),      64'd1);
    chk("setup_penable",   64'(bus.penable_o),   64'd0);
    chk("setup_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("setup_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk_bus("setup", a, w, wd, sb_exp);
    bus.pready_i  = 1'($urandom);
    bus.pslverr_i = 1'($urandom);
    bus.prdata_i  = $urandom;
    for (int k = 0; k < n_acc; k++) begin
      @(posedge clk); #1;
      chk("access_psel",      64'(bus.psel_o),      64'd1);
      chk("access_penable",   64'(bus.penable_o),   64'd1);
      chk("access_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
      chk_bus("access", a, w, wd, sb_exp);
      bus.pready_i  = (k == wait_n);
      bus.pslverr_i = (k == wait_n) ? se : 1'($urandom);
      bus.prdata_i  = (k == wait_n) ? rd : $urandom;
    end
    @(posedge clk); #1;
    bus.pready_i  = 1'($urandom);
    bus.pslverr_i = 1'($urandom);
    bus.prdata_i  = $urandom;
    chk("resp_psel",      64'(bus.psel_o),        64'd0);
    chk("resp_penable",   64'(bus.penable_o),     64'd0);
    chk("resp_valid",     64'(bus.rsp_valid_o),   64'd1);
    chk("resp_rdata",     64'(bus.rsp_rdata_o),   64'(rd_exp));
    chk("resp_err",       64'(bus.rsp_err_o),     64'(err_exp));
    chk("resp_timeout",   64'(bus.rsp_timeout_o), 64'(to_exp));
    chk("resp_req_ready", 64'(bus.req_ready_o),   64'd0);
    chk_bus("resp_hold", a, w, wd, sb_exp);
    for (int s = 0; s < stall; s++) begin
      bus.req_valid_i = 1'b1;
      bus.rsp_ready_i = 1'b0;
      @(posedge clk); #1;
      chk("stall_valid",     64'(bus.rsp_valid_o),   64'd1);
      chk("stall_rdata",     64'(bus.rsp_rdata_o),   64'(rd_exp));
      chk("stall_err",       64'(bus.rsp_err_o),     64'(err_exp));
      chk("stall_timeout",   64'(bus.rsp_timeout_o), 64'(to_exp));
      chk("stall_req_ready", 64'(bus.req_ready_o),   64'd0);
      chk("stall_psel",      64'(bus.psel_o),        64'd0);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    chk("done_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("done_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("done_psel",      64'(bus.psel_o),      64'd0);
    chk_bus("idle_hold", a, w, wd, sb_exp);
  endtask

  // Reset asserted in the middle of an ACCESS phase.
  task automatic do_reset_mid();
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = 32'h0000_0100;
    bus.req_write_i = 1'b0;
    bus.req_wdata_i = 32'h0;
    bus.req_strb_i  = 4'h0;
    bus.pready_i    = 1'b0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_pre_penable", 64'(bus.penable_o), 64'd1);
    #2 rst_n = 1'b1;
    #1;
    chk("rstmid_psel_async",    64'(bus.psel_o),    64'd0);
    chk("rstmid_penable_async", 64'(bus.penable_o), 64'd0);
    @(posedge clk); #1;
    chk("rstmid_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstmid_req_ready", 64'(bus.req_ready_o), 64'd1);
    chk("rstmid_rsp_valid2", 64'(bus.rsp_valid_o), 64'd0);
    chk("rstmid_psel",       64'(bus.psel_o),      64'd0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_write_i = 1'b0;
    bus.req_wdata_i = '0;
    bus.req_strb_i  = '0;
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b0;
    bus.prdata_i    = '0;
    bus.pslverr_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psel",        64'(bus.psel_o),        64'd0);
    chk("rst_penable",     64'(bus.penable_o),     64'd0);
    chk("rst_rsp_valid",   64'(bus.rsp_valid_o),   64'd0);
    chk("rst_rsp_err",     64'(bus.rsp_err_o),     64'd0);
    chk("rst_rsp_timeout", 64'(bus.rsp_timeout_o), 64'd0);
    chk("rst_rsp_rdata",   64'(bus.rsp_rdata_o),   64'd0);
    chk_bus("rst", 32'h0, 1'b0, 32'h0, 4'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_req_ready", 64'(bus.req_ready_o), 64'd1);

    // 1: immediate read
    do_xfer(32'h0003_0004, 1'b0, 32'h5555_AAAA, 4'hF, 0, 1'b0, 32'h0123_4567, 0);
    // 2: write, 3 wait cycles, slave error
    do_xfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 1'b1, 32'hFFFF_FFFF, 0);
    // 3: slave never ready -> watchdog
    do_xfer(32'h0000_0020, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h0, 0);
    // 4: pready on the last allowed ACCESS cycle wins
    do_xfer(32'h0000_0024, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 32'hCAFE_F00D, 0);
    // 5: response stalled 10 cycles with a request pending, then back-to-back
    do_xfer(32'h0000_0030, 1'b1, 32'h1234_5678, 4'h5, 1, 1'b0, 32'h0, 10);
    do_xfer(32'h0000_0034, 1'b0, 32'h0, 4'hA, 0, 1'b0, 32'h8765_4321, 0);
    // 6: reset during ACCESS, then a normal read
    do_reset_mid();
    do_xfer(32'h0000_0040, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0BAD_C0DE, 0);

    // randomized transfers, including watchdog expiries (wait_n >= TO)
    for (int i = 0; i < 30; i++) begin
      do_xfer($urandom, 1'($urandom), $urandom, 4'($urandom),
              int'($urandom_range(0, 6)), 1'($urandom), $urandom,
              int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
